cam_capture_ctrl: RTL and testbench
===================================

# cam_capture_ctrl

Frame-capture sequencer for the conditioned camera stream. It sits downstream of the camera input conditioning stage, which supplies registered, polarity-normalised VSYNC/HSYNC/DE/FIELD and left/right pixel data. On software request it arms, waits for a clean frame start, and generates frame-buffer write strobes, linear addresses and packed L/R data for one frame or continuously. At frame end it reports completion and geometry-error status.

## Interface
- PIXEL_WIDTH, 8, bits per pixel per channel
- H_ACTIVE, 640, expected pixels per line
- V_ACTIVE, 480, expected lines per frame
- ADDR_WIDTH, 19, write address width; must hold H_ACTIVE*V_ACTIVE-1
- CLK  in  1  single clock; all logic on posedge
- RST  in  1  reset, synchronous, active-high
- iSTART  in  1  one-cycle request to arm capture; ignored unless IDLE
- iABORT  in  1  return to IDLE from any state; no oDONE
- iCONTINUOUS  in  1  sampled at frame end: 1 = re-arm, 0 = IDLE
- iFIELD_SEL  in  1  field to capture (used only with CAPTURE_FIELD_SEL_EN)
- iVSYNC, iHSYNC, iDE, iFIELD  in  1 each  conditioned stream, active-high
- iDATA_L, iDATA_R  in  PIXEL_WIDTH each  pixel data
- oWR_EN  out  1  frame-buffer write strobe
- oWR_ADDR  out  ADDR_WIDTH  write address
- oWR_DATA  out  2*PIXEL_WIDTH  {iDATA_L, iDATA_R}
- oBUSY  out  1  high in any state except IDLE
- oDONE  out  1  one-cycle pulse at frame completion
- oSTATUS  out  4  [0] long line, [1] short line, [2] too many lines, [3] too few lines

## Operation
- Edge detection: registered copies of iVSYNC/iHSYNC. Rise = input 1 and previous 0. Fall = input 0 and previous 1.
- IDLE: iSTART -> ARM. On ARM entry, clear oSTATUS, counters and address.
- ARM: wait for a VSYNC rise, then go to FCHK if the macro is on, else CAPTURE. If VSYNC is already high when arming, wait for the next rise; no mid-frame capture.
- CAPTURE, each iDE cycle:
  - If pix_cnt < H_ACTIVE and line_cnt < V_ACTIVE: write pixel at line_base+pix_cnt, then pix_cnt++.
  - Else drop the pixel and set STATUS[0] (long line) or STATUS[2] (too many lines).
- CAPTURE, HSYNC fall with pix_cnt > 0 (line close):
  - If pix_cnt < H_ACTIVE, set STATUS[1].
  - line_cnt++ (saturating), line_base += H_ACTIVE, pix_cnt = 0.
  - Lines with zero pixels are not counted.
- CAPTURE, VSYNC fall -> FINISH.
- FINISH (one cycle): if line_cnt < V_ACTIVE, set STATUS[3]; pulse oDONE. Then go to ARM if iCONTINUOUS, else IDLE.
- oSTATUS is valid with oDONE and held until the next ARM entry.
- Precedence:
  - RST overrides everything.
  - iABORT beats iSTART and all stream events.
  - A same-cycle DE write goes into the current line before that cycle's HSYNC line close.
  - A same-cycle HSYNC fall closes its line before a VSYNC fall finishes the frame.
- Pixels arriving in the VSYNC-rise cycle are not captured.
- Arithmetic: address is never multiplied; it is line_base + pix_cnt with line_base accumulated. Dropped pixels never advance the address.

## Timing
- Reset: state IDLE; oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE, oSTATUS all 0.
- Write latency 1: iDE/data sampled at edge n -> oWR_EN/oWR_ADDR/oWR_DATA valid for the cycle after edge n. oWR_EN is high exactly one cycle per accepted pixel.
- oBUSY rises the cycle after iSTART is accepted.
- oDONE is asserted one cycle after the VSYNC-fall cycle. In continuous mode, oBUSY stays high through FINISH.
- The last write (pixel coincident with VSYNC fall) is issued in the same cycle as oDONE.

## Configuration
- CAPTURE_FIELD_SEL_EN defined:
  - A VSYNC rise in ARM goes to FCHK.
  - FCHK lasts one cycle and compares iFIELD with iFIELD_SEL: match -> CAPTURE; mismatch -> ARM (wait for the next rise, no writes, no oDONE).
  - Pixels in the FCHK cycle are not captured.
- Not defined: FCHK is absent; iFIELD and iFIELD_SEL are ignored.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=3.
- Nominal single-shot: pulse iSTART, one frame of 3 lines x 4 pixels with data L=addr, R=~addr -> 12 writes at addresses 0..11, oWR_DATA correct, one oDONE, oSTATUS=0, return to IDLE.
- Geometry errors: line 0 has 5 DE, line 1 has 3, only 2 lines -> 5th pixel dropped, addresses 0-3 then 4-6; oSTATUS=4'b1011 at oDONE.
- Arm mid-frame: iSTART while VSYNC is high -> no writes until the next VSYNC rise; the next frame is captured completely.
- Continuous and abort: iCONTINUOUS=1 for two frames -> two oDONE pulses, address restarts at 0. iABORT mid-line in frame 3 -> oWR_EN low the next cycle, no oDONE, oBUSY=0.
- Simultaneous events: last DE coincident with HSYNC fall and VSYNC fall -> pixel written at address 11, lines=3, oSTATUS=0. iSTART and iABORT in the same cycle -> stays IDLE.
- Macro on: iFIELD_SEL=1 with frames of FIELD 0 then 1 -> first frame skipped, second captured, exactly one oDONE.

Source files
------------

// File: rtl/cam_capture_ctrl_if.sv
// Stream-in / frame-buffer-out bundle for cam_capture_ctrl.
// slave = the capture controller, master = whoever drives the stream and control.
interface cam_capture_ctrl_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 19
);
  logic                     iSTART;
  logic                     iABORT;
  logic                     iCONTINUOUS;
  logic                     iFIELD_SEL;
  logic                     iVSYNC;
  logic                     iHSYNC;
  logic                     iDE;
  logic                     iFIELD;
  logic [PIXEL_WIDTH-1:0]   iDATA_L;
  logic [PIXEL_WIDTH-1:0]   iDATA_R;
  logic                     oWR_EN;
  logic [ADDR_WIDTH-1:0]    oWR_ADDR;
  logic [2*PIXEL_WIDTH-1:0] oWR_DATA;
  logic                     oBUSY;
  logic                     oDONE;
  logic [3:0]               oSTATUS;

  modport slave (
    input  iSTART, iABORT, iCONTINUOUS, iFIELD_SEL,
    input  iVSYNC, iHSYNC, iDE, iFIELD, iDATA_L, iDATA_R,
    output oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE, oSTATUS
  );

  modport master (
    output iSTART, iABORT, iCONTINUOUS, iFIELD_SEL,
    output iVSYNC, iHSYNC, iDE, iFIELD, iDATA_L, iDATA_R,
    input  oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE, oSTATUS
  );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: arms on request, writes one frame (or continuously) as
// linear addresses. Optional field filter enabled by defining CAPTURE_FIELD_SEL_EN.
module cam_capture_ctrl #(
  parameter int PIXEL_WIDTH = 8,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_WIDTH  = 19
) (
  input  logic              CLK,
  input  logic              RST,
  cam_capture_ctrl_if.slave bus
);

  localparam int PCW = $clog2(H_ACTIVE + 1);
  localparam int LCW = $clog2(V_ACTIVE + 1);
  localparam logic [PCW-1:0]        H_MAX  = PCW'(H_ACTIVE);
  localparam logic [LCW-1:0]        V_MAX  = LCW'(V_ACTIVE);
  localparam logic [ADDR_WIDTH-1:0] H_STEP = ADDR_WIDTH'(H_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
`ifdef CAPTURE_FIELD_SEL_EN
    S_FCHK,
`endif
    S_CAPTURE,
    S_FINISH
  } state_e;

  state_e                   state_q, state_d;
  logic                     vs_q, hs_q;
  logic [PCW-1:0]           pix_q, pix_d;
  logic [LCW-1:0]           line_q, line_d;
  logic [ADDR_WIDTH-1:0]    base_q, base_d;
  logic [3:0]               status_q, status_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [2*PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     vs_rise, vs_fall, hs_fall;

  assign vs_rise = bus.iVSYNC & ~vs_q;
  assign vs_fall = ~bus.iVSYNC & vs_q;
  assign hs_fall = ~bus.iHSYNC & hs_q;

`ifndef CAPTURE_FIELD_SEL_EN
  logic unused_field;
  assign unused_field = bus.iFIELD ^ bus.iFIELD_SEL;
`endif

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    line_d    = line_q;
    base_d    = base_q;
    status_d  = status_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    if (bus.iABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.iSTART) begin
            state_d  = S_ARM;
            pix_d    = '0;
            line_d   = '0;
            base_d   = '0;
            status_d = '0;
          end
        end
        S_ARM: begin
          if (vs_rise) begin
`ifdef CAPTURE_FIELD_SEL_EN
            state_d = S_FCHK;
`else
            state_d = S_CAPTURE;
`endif
          end
        end
`ifdef CAPTURE_FIELD_SEL_EN
        S_FCHK: begin
          state_d = (bus.iFIELD == bus.iFIELD_SEL) ? S_CAPTURE : S_ARM;
        end
`endif
        S_CAPTURE: begin
          if (bus.iDE) begin
            if (pix_q < H_MAX && line_q < V_MAX) begin
              wr_en_d   = 1'b1;
              wr_addr_d = base_q + ADDR_WIDTH'(pix_q);
              wr_data_d = {bus.iDATA_L, bus.iDATA_R};
              pix_d     = pix_q + 1'b1;
            end else if (line_q >= V_MAX) begin
              status_d[2] = 1'b1;
            end else begin
              status_d[0] = 1'b1;
            end
          end
          // pix_d already includes this cycle's pixel, so it lands in the line being closed
          if (hs_fall && pix_d != '0) begin
            if (pix_d < H_MAX) status_d[1] = 1'b1;
            if (line_q < V_MAX) line_d = line_q + 1'b1;
            base_d = base_q + H_STEP;
            pix_d  = '0;
          end
          // Completion is flagged on entry to FINISH so oDONE/oSTATUS line up with the last write
          if (vs_fall) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            if (line_d < V_MAX) status_d[3] = 1'b1;
          end
        end
        S_FINISH: begin
          if (bus.iCONTINUOUS) begin
            state_d  = S_ARM;
            pix_d    = '0;
            line_d   = '0;
            base_d   = '0;
            status_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      pix_q     <= '0;
      line_q    <= '0;
      base_q    <= '0;
      status_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= bus.iVSYNC;
      hs_q      <= bus.iHSYNC;
      pix_q     <= pix_d;
      line_q    <= line_d;
      base_q    <= base_d;
      status_q  <= status_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.oWR_EN   = wr_en_q;
  assign bus.oWR_ADDR = wr_addr_q;
  assign bus.oWR_DATA = wr_data_q;
  assign bus.oBUSY    = busy_q;
  assign bus.oDONE    = done_q;
  assign bus.oSTATUS  = status_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl with a 4x3 geometry; expected writes and status are
// derived per frame from the recorded line lengths and pixel data.
module tb_cam_capture_ctrl;
  localparam int PW = 8;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [2*PW-1:0] d;
  } wr_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  cam_capture_ctrl_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  cam_capture_ctrl #(
    .PIXEL_WIDTH(PW), .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  wr_t act_q[$];
  wr_t exp_q[$];
  logic [2*PW-1:0] px_data[$];
  int line_n[$];
  int np[8];
  int done_cnt = 0;
  logic [3:0] done_status = '0;
  logic done_with_wr = 1'b0;
  bit nominal_data = 1'b0;
  int frame_no = 0;

  always @(negedge CLK) begin
    if (bus.oWR_EN) act_q.push_back({bus.oWR_ADDR, bus.oWR_DATA});
    if (bus.oDONE) begin
      done_cnt++;
      done_status = bus.oSTATUS;
      done_with_wr = bus.oWR_EN;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit vs, input bit hs, input bit de, input logic [2*PW-1:0] d = '0);
    bus.iVSYNC  = vs;
    bus.iHSYNC  = hs;
    bus.iDE     = de;
    bus.iDATA_L = d[2*PW-1:PW];
    bus.iDATA_R = d[PW-1:0];
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input bit vs);
    bus.iSTART = 1'b1;
    cyc(vs, 1'b0, 1'b0);
    bus.iSTART = 1'b0;
    check("busy_after_start", 32'(bus.oBUSY), 32'd1);
  endtask

  // Drives one frame: VSYNC rise, nl lines of np[i] pixels with random gaps, VSYNC fall.
  // With coincide set, the last pixel shares its cycle with the HSYNC and VSYNC falls.
  task automatic run_frame(input int nl, input bit coincide);
    int pidx = 0;
    logic [2*PW-1:0] d;
    logic [7:0] pb;
    line_n.delete();
    px_data.delete();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int li = 0; li < nl; li++) begin
      line_n.push_back(np[li]);
      for (int p = 0; p < np[li]; p++) begin
        repeat ($urandom_range(0, 1)) cyc(1, 1, 0);
        pb = 8'(pidx);
        d = nominal_data ? {pb, ~pb} : 16'($urandom);
        pidx++;
        px_data.push_back(d);
        if (coincide && li == nl - 1 && p == np[li] - 1) cyc(0, 0, 1, d);
        else cyc(1, 1, 1, d);
      end
      if (!(coincide && li == nl - 1)) begin
        if (np[li] == 0) cyc(1, 1, 0);
        cyc(1, 0, 0);
      end
    end
    if (!coincide) cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
  endtask

  // Reference: k-th non-empty line fills addresses k*H .. k*H+min(n,H)-1.
  task automatic build_expect(output logic [3:0] st);
    int k = 0;
    int idx = 0;
    st = '0;
    exp_q.delete();
    foreach (line_n[i]) begin
      int n = line_n[i];
      if (n == 0) continue;
      if (k < V) begin
        for (int j = 0; j < n && j < H; j++)
          exp_q.push_back({AW'(k * H + j), px_data[idx + j]});
        if (n > H) st[0] = 1'b1;
        if (n < H) st[1] = 1'b1;
        k++;
      end else begin
        st[2] = 1'b1;
      end
      idx += n;
    end
    if (k < V) st[3] = 1'b1;
  endtask

  task automatic compare_frame(input string tag, input int exp_done, input bit exp_busy,
                               input logic [3:0] exp_st);
    check({tag, "_nwr"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    if (exp_done > 0) check({tag, "_status"}, 32'(done_status), 32'(exp_st));
    check({tag, "_busy"}, 32'(bus.oBUSY), 32'(exp_busy));
    $display("frame %0d %s: writes=%0d done=%0d status=%b", frame_no, tag, act_q.size(),
             done_cnt, done_status);
    frame_no++;
    act_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    logic [3:0] st;
    int nl;
    bit coin;
    bus.iSTART = 0; bus.iABORT = 0; bus.iCONTINUOUS = 0; bus.iFIELD_SEL = 0;
    bus.iFIELD = 0; bus.iVSYNC = 0; bus.iHSYNC = 0; bus.iDE = 0;
    bus.iDATA_L = '0; bus.iDATA_R = '0;

    RST = 1'b1;
    repeat (3) cyc(0, 0, 0);
    check("rst_wr_en", 32'(bus.oWR_EN), 0);
    check("rst_wr_addr", 32'(bus.oWR_ADDR), 0);
    check("rst_wr_data", 32'(bus.oWR_DATA), 0);
    check("rst_busy", 32'(bus.oBUSY), 0);
    check("rst_done", 32'(bus.oDONE), 0);
    check("rst_status", 32'(bus.oSTATUS), 0);
    RST = 1'b0;
    cyc(0, 0, 0);

    // Nominal single frame, data L=addr R=~addr
    nominal_data = 1'b1;
    np[0] = 4; np[1] = 4; np[2] = 4;
    start(0);
    run_frame(3, 0);
    build_expect(st);
    compare_frame("nominal", 1, 0, 4'b0000);
    nominal_data = 1'b0;

    // Long line 0, short line 1, only two lines
    np[0] = 5; np[1] = 3;
    start(0);
    run_frame(2, 0);
    build_expect(st);
    compare_frame("geometry", 1, 0, 4'b1011);

    // Armed while VSYNC high: the in-progress frame must be ignored
    cyc(1, 0, 0);
    start(1);
    repeat (3) cyc(1, 1, 1, 16'hA5A5);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    np[0] = 4; np[1] = 4; np[2] = 4;
    run_frame(3, 0);
    build_expect(st);
    compare_frame("midframe", 1, 0, st);

    // Continuous: two frames, then abort mid-line in the third
    bus.iCONTINUOUS = 1'b1;
    start(0);
    np[0] = 4; np[1] = 2; np[2] = 4;
    run_frame(3, 0);
    build_expect(st);
    compare_frame("cont1", 1, 1, st);
    np[0] = 4; np[1] = 4; np[2] = 4; np[3] = 1;
    run_frame(4, 0);
    build_expect(st);
    compare_frame("cont2", 1, 1, st);
    cyc(1, 0, 0);
    cyc(1, 1, 1, 16'h1111);
    cyc(1, 1, 1, 16'h2222);
    bus.iABORT = 1'b1;
    cyc(1, 1, 1, 16'h3333);
    bus.iABORT = 1'b0;
    check("abort_wr_en", 32'(bus.oWR_EN), 0);
    check("abort_busy", 32'(bus.oBUSY), 0);
    cyc(1, 1, 1, 16'h4444);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    exp_q.delete();
    exp_q.push_back({4'd0, 16'h1111});
    exp_q.push_back({4'd1, 16'h2222});
    compare_frame("abort", 0, 0, 4'b0000);
    bus.iCONTINUOUS = 1'b0;

    // Last pixel coincident with HSYNC fall and VSYNC fall
    np[0] = 4; np[1] = 4; np[2] = 4;
    start(0);
    run_frame(3, 1);
    build_expect(st);
    check("coincide_done_with_wr", 32'(done_with_wr), 1);
    compare_frame("coincide", 1, 0, 4'b0000);

    // iSTART and iABORT together: must stay idle
    bus.iSTART = 1'b1;
    bus.iABORT = 1'b1;
    cyc(0, 0, 0);
    bus.iSTART = 1'b0;
    bus.iABORT = 1'b0;
    check("start_abort_busy", 32'(bus.oBUSY), 0);
    run_frame(3, 0);
    exp_q.delete();
    compare_frame("start_abort", 0, 0, 4'b0000);

    // Randomized single-shot frames
    for (int f = 0; f < 6; f++) begin
      nl = $urandom_range(1, 5);
      for (int li = 0; li < 8; li++) np[li] = $urandom_range(0, 6);
      coin = 1'($urandom_range(0, 1));
      if (coin && np[nl - 1] == 0) np[nl - 1] = 1;
      start(0);
      run_frame(nl, coin);
      build_expect(st);
      compare_frame("random", 1, 0, st);
    end

`ifdef CAPTURE_FIELD_SEL_EN
    // Field filter: field 0 frame skipped, field 1 frame captured
    bus.iFIELD_SEL = 1'b1;
    bus.iFIELD = 1'b0;
    np[0] = 4; np[1] = 4; np[2] = 4;
    start(0);
    run_frame(3, 0);
    bus.iFIELD = 1'b1;
    run_frame(3, 0);
    build_expect(st);
    compare_frame("field_sel", 1, 0, 4'b0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
